slv_guard_err_slv: RTL and testbench

- Error-terminating AXI subordinate used on the manager side of the slave guard once the guard isolates the real subordinate (reset request or interrupt).
- Accepts manager AW/W/AR traffic and completes every transaction locally with SLVERR, so managers never hang on an isolated subordinate.
- Write and read channels are handled independently.
- Saturating counters report terminated transactions to the guard register file.

---
 rtl/slv_guard_err_pkg.sv | 68 ++++++
 rtl/slv_guard_err_rd_unit.sv | 67 ++++++
 rtl/slv_guard_err_slv.sv | 130 +++++++++++++
 tb/tb_slv_guard_err_slv.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slv_guard_err_pkg.sv
// Shared types and constants for the slave-guard error subordinate.
// The default AXI request/response structs match the default port widths of the top.
package slv_guard_err_pkg;

    localparam int unsigned BEAT_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_e;

    typedef struct packed {
        logic [1:0]        id;
        logic [31:0]       addr;
        logic [BEAT_W-1:0] len;
    } axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } axi_w_t;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
        logic       user;
    } axi_b_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic        user;
    } axi_r_t;

    typedef struct packed {
        axi_ax_t aw;
        logic    aw_valid;
        axi_w_t  w;
        logic    w_valid;
        logic    b_ready;
        axi_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        logic    ar_ready;
        axi_b_t  b;
        logic    b_valid;
        axi_r_t  r;
        logic    r_valid;
    } axi_rsp_t;

endpackage

// File: rtl/slv_guard_err_rd_unit.sv
// Read side of the error subordinate: accepts one AR, then streams len+1 SLVERR beats.
module slv_guard_err_rd_unit
    import slv_guard_err_pkg::*;
#(
    parameter int unsigned IdWidth = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_accept,
    input  logic               i_ar_valid,
    input  logic [IdWidth-1:0] i_ar_id,
    input  logic [BEAT_W-1:0]  i_ar_len,
    input  logic               i_r_ready,
    output logic               o_ar_ready,
    output logic               o_r_valid,
    output logic [IdWidth-1:0] o_r_id,
    output logic               o_r_last,
    output logic               o_done,
    output logic               o_busy
);

    rd_state_e          r_state;
    logic [IdWidth-1:0] r_id;
    logic [BEAT_W-1:0]  r_len;
    logic [BEAT_W-1:0]  r_beat;
    logic               w_last;

    assign w_last = (r_beat == r_len);

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and simulation order cannot change the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_beat  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (i_ar_valid && o_ar_ready) begin
                        r_id    <= i_ar_id;
                        r_len   <= i_ar_len;
                        r_beat  <= '0;
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    // The beat counter stops at len, so len = 255 never wraps.
                    if (i_r_ready) begin
                        if (w_last) r_state <= R_IDLE;
                        else        r_beat  <= r_beat + 1'b1;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign o_ar_ready = (r_state == R_IDLE) && i_accept;
    assign o_r_valid  = (r_state == R_DATA);
    assign o_r_id     = o_r_valid ? r_id : '0;
    assign o_r_last   = o_r_valid && w_last;
    assign o_done     = o_r_valid && i_r_ready && w_last;
    assign o_busy     = o_r_valid;

endmodule

// File: rtl/slv_guard_err_slv.sv
// Error-terminating AXI subordinate: completes every accepted write and read with SLVERR
// while the guard isolates the real subordinate, and counts terminated transactions.
module slv_guard_err_slv
    import slv_guard_err_pkg::*;
#(
    parameter int unsigned AxiIdWidth = 2,
    parameter int unsigned DataWidth  = 32,
    parameter logic [31:0] RespData   = 32'hBADCAB1E,
    parameter int unsigned CntWidth   = 6,
    parameter type         req_t      = axi_req_t,
    parameter type         rsp_t      = axi_rsp_t
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                isolate_i,
    input  req_t                req_i,
    output rsp_t                rsp_o,
    input  logic                cnt_clr_i,
    output logic [CntWidth-1:0] wr_err_cnt_o,
    output logic [CntWidth-1:0] rd_err_cnt_o,
    output logic                busy_o
);

    localparam logic [DataWidth-1:0] RESP_DATA = DataWidth'(RespData);

    wr_state_e             r_wr_state;
    logic [AxiIdWidth-1:0] r_aw_id;
    logic                  r_iso;
    logic [CntWidth-1:0]   r_wr_cnt;
    logic [CntWidth-1:0]   r_rd_cnt;

    logic                  w_aw_ready;
    logic                  w_w_ready;
    logic                  w_b_valid;
    logic                  w_wr_done;
    logic                  w_ar_ready;
    logic                  w_r_valid;
    logic [AxiIdWidth-1:0] w_r_id;
    logic                  w_r_last;
    logic                  w_rd_done;
    logic                  w_rd_busy;
    logic                  w_unused_req;

    // Registering isolate keeps every rsp_o field a pure decode of flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_iso <= 1'b0;
        else         r_iso <= isolate_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_state <= W_IDLE;
            r_aw_id    <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (req_i.aw_valid && w_aw_ready) begin
                        r_aw_id    <= req_i.aw.id;
                        r_wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (req_i.w_valid && req_i.w.last) r_wr_state <= W_RESP;
                end
                W_RESP: begin
                    if (req_i.b_ready) r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign w_aw_ready = (r_wr_state == W_IDLE) && r_iso;
    assign w_w_ready  = (r_wr_state == W_DATA);
    assign w_b_valid  = (r_wr_state == W_RESP);
    assign w_wr_done  = w_b_valid && req_i.b_ready;

    slv_guard_err_rd_unit #(
        .IdWidth (AxiIdWidth)
    ) u_rd_unit (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_accept   (r_iso),
        .i_ar_valid (req_i.ar_valid),
        .i_ar_id    (req_i.ar.id),
        .i_ar_len   (req_i.ar.len),
        .i_r_ready  (req_i.r_ready),
        .o_ar_ready (w_ar_ready),
        .o_r_valid  (w_r_valid),
        .o_r_id     (w_r_id),
        .o_r_last   (w_r_last),
        .o_done     (w_rd_done),
        .o_busy     (w_rd_busy)
    );

    // Clear wins over a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
        end else begin
            if (w_wr_done && (r_wr_cnt != '1)) r_wr_cnt <= r_wr_cnt + 1'b1;
            if (w_rd_done && (r_rd_cnt != '1)) r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    always_comb begin
        rsp_o          = '0;
        rsp_o.aw_ready = w_aw_ready;
        rsp_o.w_ready  = w_w_ready;
        rsp_o.ar_ready = w_ar_ready;
        rsp_o.b_valid  = w_b_valid;
        rsp_o.b.id     = w_b_valid ? r_aw_id : '0;
        rsp_o.b.resp   = w_b_valid ? RESP_SLVERR : RESP_OKAY;
        rsp_o.r_valid  = w_r_valid;
        rsp_o.r.id     = w_r_id;
        rsp_o.r.data   = w_r_valid ? RESP_DATA : '0;
        rsp_o.r.resp   = w_r_valid ? RESP_SLVERR : RESP_OKAY;
        rsp_o.r.last   = w_r_last;
    end

    assign wr_err_cnt_o = r_wr_cnt;
    assign rd_err_cnt_o = r_rd_cnt;
    assign busy_o       = (r_wr_state != W_IDLE) || w_rd_busy;
    assign w_unused_req = ^req_i;

endmodule

// File: tb/tb_slv_guard_err_slv.sv
// Directed self-checking bench for slv_guard_err_slv: write/read termination, gating,
// concurrency with len 255/0, counter saturation and clear, and reset mid-burst.
module tb_slv_guard_err_slv;
    import slv_guard_err_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       isolate = 1'b0;
    logic       cnt_clr = 1'b0;
    axi_req_t   req;
    axi_rsp_t   rsp;
    logic [5:0] wr_cnt;
    logic [5:0] rd_cnt;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    slv_guard_err_slv dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .isolate_i    (isolate),
        .req_i        (req),
        .rsp_o        (rsp),
        .cnt_clr_i    (cnt_clr),
        .wr_err_cnt_o (wr_cnt),
        .rd_err_cnt_o (rd_cnt),
        .busy_o       (busy)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nbeats;
        int last_bad;

        req = '0;
        #12;
        check("reset_rsp_zero", 32'(rsp == '0), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_wr_cnt", 32'(wr_cnt), 32'd0);
        check("reset_rd_cnt", 32'(rd_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Write termination: AW id 01, four W beats.
        isolate = 1'b1;
        tick();
        check("wr_aw_ready", 32'(rsp.aw_ready), 32'd1);
        req.aw_valid = 1'b1;
        req.aw.id    = 2'b01;
        tick();
        req.aw_valid = 1'b0;
        check("wr_aw_ready_drop", 32'(rsp.aw_ready), 32'd0);
        check("wr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            req.w_valid = 1'b1;
            req.w.last  = (i == 3);
            check("wr_w_ready", 32'(rsp.w_ready), 32'd1);
            check("wr_no_b_early", 32'(rsp.b_valid), 32'd0);
            tick();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        check("wr_w_ready_off", 32'(rsp.w_ready), 32'd0);
        check("wr_b_valid", 32'(rsp.b_valid), 32'd1);
        check("wr_b_id", 32'(rsp.b.id), 32'h1);
        check("wr_b_resp", 32'(rsp.b.resp), 32'h2);
        check("wr_b_user", 32'(rsp.b.user), 32'h0);
        tick();
        check("wr_b_hold", 32'(rsp.b_valid), 32'd1);
        check("wr_b_id_hold", 32'(rsp.b.id), 32'h1);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("wr_b_done", 32'(rsp.b_valid), 32'd0);
        check("wr_cnt_1", 32'(wr_cnt), 32'd1);

        // Read burst: id 11, len 3, r_ready toggling.
        check("rd_ar_ready", 32'(rsp.ar_ready), 32'd1);
        req.ar_valid = 1'b1;
        req.ar.id    = 2'b11;
        req.ar.len   = 8'd3;
        tick();
        req.ar_valid = 1'b0;
        nbeats = 0;
        for (int c = 0; c < 20 && nbeats < 4; c++) begin
            req.r_ready = (c % 2 == 0);
            check("rd_r_valid", 32'(rsp.r_valid), 32'd1);
            check("rd_r_data", rsp.r.data, 32'hBADCAB1E);
            check("rd_r_resp", 32'(rsp.r.resp), 32'h2);
            check("rd_r_id", 32'(rsp.r.id), 32'h3);
            check("rd_r_last", 32'(rsp.r.last), 32'(nbeats == 3));
            if (req.r_ready) nbeats++;
            tick();
        end
        req.r_ready = 1'b0;
        check("rd_beats", 32'(nbeats), 32'd4);
        check("rd_r_valid_off", 32'(rsp.r_valid), 32'd0);
        check("rd_cnt_1", 32'(rd_cnt), 32'd1);

        // Gating: isolate low blocks new AW/AR.
        isolate = 1'b0;
        tick();
        req.aw_valid = 1'b1;
        req.ar_valid = 1'b1;
        tick();
        check("gate_aw_ready", 32'(rsp.aw_ready), 32'd0);
        check("gate_ar_ready", 32'(rsp.ar_ready), 32'd0);
        check("gate_busy", 32'(busy), 32'd0);
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;

        // Isolate dropped during W_DATA: burst still completes.
        isolate = 1'b1;
        tick();
        req.aw_valid = 1'b1;
        req.aw.id    = 2'b10;
        tick();
        req.aw_valid = 1'b0;
        isolate      = 1'b0;
        check("gate_w_data", 32'(rsp.w_ready), 32'd1);
        req.w_valid = 1'b1;
        tick();
        req.w.last = 1'b1;
        tick();
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
        check("gate_b_valid", 32'(rsp.b_valid), 32'd1);
        check("gate_b_resp", 32'(rsp.b.resp), 32'h2);
        check("gate_b_id", 32'(rsp.b.id), 32'h2);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("gate_wr_cnt", 32'(wr_cnt), 32'd2);
        check("gate_aw_closed", 32'(rsp.aw_ready), 32'd0);

        // Concurrent AW + AR with len 255; write B waits independently.
        isolate = 1'b1;
        tick();
        req.aw_valid = 1'b1;
        req.aw.id    = 2'b00;
        req.ar_valid = 1'b1;
        req.ar.id    = 2'b10;
        req.ar.len   = 8'd255;
        check("conc_aw_ready", 32'(rsp.aw_ready), 32'd1);
        check("conc_ar_ready", 32'(rsp.ar_ready), 32'd1);
        tick();
        req.aw_valid = 1'b0;
        req.ar_valid = 1'b0;
        check("conc_w_ready", 32'(rsp.w_ready), 32'd1);
        check("conc_r_valid", 32'(rsp.r_valid), 32'd1);
        req.w_valid = 1'b1;
        req.w.last  = 1'b1;
        req.r_ready = 1'b1;
        nbeats   = 0;
        last_bad = 0;
        for (int c = 0; c < 400 && nbeats < 256; c++) begin
            if (rsp.r_valid) begin
                if (rsp.r.last !== (nbeats == 255)) last_bad++;
                nbeats++;
            end
            tick();
            req.w_valid = 1'b0;
            req.w.last  = 1'b0;
        end
        req.r_ready = 1'b0;
        check("conc_beats_256", 32'(nbeats), 32'd256);
        check("conc_last_pos", 32'(last_bad), 32'd0);
        check("conc_r_done", 32'(rsp.r_valid), 32'd0);
        check("conc_b_waiting", 32'(rsp.b_valid), 32'd1);
        check("conc_b_id", 32'(rsp.b.id), 32'h0);
        req.b_ready = 1'b1;
        tick();
        req.b_ready = 1'b0;
        check("conc_wr_cnt", 32'(wr_cnt), 32'd3);
        check("conc_rd_cnt", 32'(rd_cnt), 32'd2);

        // len 0: exactly one beat with last.
        req.ar_valid = 1'b1;
        req.ar.len   = 8'd0;
        tick();
        req.ar_valid = 1'b0;
        check("len0_valid", 32'(rsp.r_valid), 32'd1);
        check("len0_last", 32'(rsp.r.last), 32'd1);
        req.r_ready = 1'b1;
        tick();
        check("len0_done", 32'(rsp.r_valid), 32'd0);
        check("len0_rd_cnt", 32'(rd_cnt), 32'd3);

        // Saturation: 70 more single-beat reads.
        for (int i = 0; i < 70; i++) begin
            req.ar_valid = 1'b1;
            tick();
            req.ar_valid = 1'b0;
            tick();
        end
        check("sat_rd_cnt", 32'(rd_cnt), 32'd63);

        // Clear coincident with a completing read.
        req.ar_valid = 1'b1;
        tick();
        req.ar_valid = 1'b0;
        check("clr_r_valid", 32'(rsp.r_valid), 32'd1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_rd_cnt", 32'(rd_cnt), 32'd0);
        check("clr_wr_cnt", 32'(wr_cnt), 32'd0);
        req.r_ready = 1'b0;

        // Reset mid read burst (len 7).
        req.ar_valid = 1'b1;
        req.ar.id    = 2'b01;
        req.ar.len   = 8'd7;
        tick();
        req.ar_valid = 1'b0;
        req.r_ready  = 1'b1;
        tick();
        tick();
        check("rst_pre_valid", 32'(rsp.r_valid), 32'd1);
        check("rst_pre_last", 32'(rsp.r.last), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_r_valid", 32'(rsp.r_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_zero", 32'(rsp == '0), 32'd1);
        req.r_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_ar_ready", 32'(rsp.ar_ready), 32'd1);
        req.ar_valid = 1'b1;
        req.ar.len   = 8'd0;
        tick();
        req.ar_valid = 1'b0;
        check("rst_new_r_valid", 32'(rsp.r_valid), 32'd1);
        check("rst_new_r_id", 32'(rsp.r.id), 32'h1);
        req.r_ready = 1'b1;
        tick();
        req.r_ready = 1'b0;
        check("rst_new_rd_cnt", 32'(rd_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
